// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared control struct and opcode/func constants for the MIPS pipeline
package pipe_pkg;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
    logic reg_dst;
  } ctrl_t;

  localparam logic [3:0] ALU_OP_RTYPE = 4'd0;
  localparam logic [3:0] ALU_OP_ADD   = 4'd1;
  localparam logic [3:0] ALU_OP_SUB   = 4'd2;
  localparam logic [3:0] ALU_OP_LUI   = 4'd3;
  localparam logic [3:0] ALU_OP_OR    = 4'd4;

  localparam logic [5:0] FUNC_ADDU = 6'b100001;
  localparam logic [5:0] FUNC_SUBU = 6'b100011;
  localparam logic [5:0] FUNC_JR   = 6'b001000;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard detector between EX and ID
module load_use_detect (
  input  logic       i_ex_valid,
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_dest,
  input  logic       i_id_valid,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_alu_src,
  input  logic       i_id_mem_write,
  output logic       o_hz
);

  logic w_uses_rt;
  logic w_rs_match;
  logic w_rt_match;

  // Stores read rt as the data to write even though alu_src selects the immediate.
  assign w_uses_rt  = !i_id_alu_src | i_id_mem_write;
  assign w_rs_match = (i_ex_dest == i_id_rs);
  assign w_rt_match = (i_ex_dest == i_id_rt) & w_uses_rt;

  assign o_hz = i_ex_valid & i_ex_mem_read & (i_ex_dest != 5'd0) & i_id_valid
              & (w_rs_match | w_rt_match);

endmodule

// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID/EX pipeline register with load-use stall; ID_EX_PERF_CNT_EN adds stall/bubble counters
module id_ex_stage_reg
  import pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [3:0]      id_alu_opcode,
  input  logic [5:0]      id_func,
  input  logic [XLEN-1:0] id_rs_data,
  input  logic [XLEN-1:0] id_rt_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs,
  input  logic [4:0]      id_rt,
  input  logic [4:0]      id_rd,
  input  logic [5:0]      id_ctrl,
  input  logic            flush,
  input  logic            mem_stall,
  output logic            stall_id,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs_data,
  output logic [XLEN-1:0] ex_rt_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [3:0]      ex_alu_opcode,
  output logic [5:0]      ex_func,
  output logic [4:0]      ex_rs,
  output logic [4:0]      ex_rt,
  output logic [4:0]      ex_dest,
  output logic [5:0]      ex_ctrl
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     bubble_cnt
`endif
);

  ctrl_t           w_id_ctrl;
  logic            w_hz;
  logic            w_bubble;

  logic            r_ex_valid;
  logic [XLEN-1:0] r_ex_pc;
  logic [XLEN-1:0] r_ex_rs_data;
  logic [XLEN-1:0] r_ex_rt_data;
  logic [XLEN-1:0] r_ex_imm;
  logic [3:0]      r_ex_alu_opcode;
  logic [5:0]      r_ex_func;
  logic [4:0]      r_ex_rs;
  logic [4:0]      r_ex_rt;
  logic [4:0]      r_ex_dest;
  ctrl_t           r_ex_ctrl;

  assign w_id_ctrl = ctrl_t'(id_ctrl);

  load_use_detect u_load_use_detect (
    .i_ex_valid     (r_ex_valid),
    .i_ex_mem_read  (r_ex_ctrl.mem_read),
    .i_ex_dest      (r_ex_dest),
    .i_id_valid     (id_valid),
    .i_id_rs        (id_rs),
    .i_id_rt        (id_rt),
    .i_id_alu_src   (w_id_ctrl.alu_src),
    .i_id_mem_write (w_id_ctrl.mem_write),
    .o_hz           (w_hz)
  );

  // A flush wins over the hazard so IF is free to fetch the redirect target.
  assign stall_id = mem_stall | (w_hz & !flush);
  assign w_bubble = flush | w_hz | !id_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_valid      <= 1'b0;
      r_ex_pc         <= '0;
      r_ex_rs_data    <= '0;
      r_ex_rt_data    <= '0;
      r_ex_imm        <= '0;
      r_ex_alu_opcode <= '0;
      r_ex_func       <= '0;
      r_ex_rs         <= '0;
      r_ex_rt         <= '0;
      r_ex_dest       <= '0;
      r_ex_ctrl       <= '0;
    end else if (!mem_stall) begin
      r_ex_pc      <= id_pc;
      r_ex_rs_data <= id_rs_data;
      r_ex_rt_data <= id_rt_data;
      r_ex_imm     <= id_imm;
      r_ex_rs      <= id_rs;
      r_ex_rt      <= id_rt;
      if (w_bubble) begin
        r_ex_valid      <= 1'b0;
        r_ex_alu_opcode <= ALU_OP_RTYPE;
        r_ex_func       <= '0;
        r_ex_dest       <= '0;
        r_ex_ctrl       <= '0;
      end else begin
        r_ex_valid      <= 1'b1;
        r_ex_alu_opcode <= id_alu_opcode;
        r_ex_func       <= id_func;
        r_ex_dest       <= w_id_ctrl.reg_dst ? id_rd : id_rt;
        r_ex_ctrl       <= w_id_ctrl;
      end
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else if (!mem_stall) begin
      if (w_hz && !flush && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_bubble && (r_bubble_cnt != 32'hFFFF_FFFF))
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`endif

  assign ex_valid      = r_ex_valid;
  assign ex_pc         = r_ex_pc;
  assign ex_rs_data    = r_ex_rs_data;
  assign ex_rt_data    = r_ex_rt_data;
  assign ex_imm        = r_ex_imm;
  assign ex_alu_opcode = r_ex_alu_opcode;
  assign ex_func       = r_ex_func;
  assign ex_rs         = r_ex_rs;
  assign ex_rt         = r_ex_rt;
  assign ex_dest       = r_ex_dest;
  assign ex_ctrl       = r_ex_ctrl;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb/tb_id_ex_stage_reg.sv - scoreboard bench for id_ex_stage_reg; ID_EX_PERF_CNT_EN enables counter checks
module tb_id_ex_stage_reg;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [3:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs, rt, rd, dest;
    logic [5:0]  ctrl;
    logic        flush, mstall;
  } stim_t;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [3:0]  op;
    logic [5:0]  fn;
    logic [4:0]  dest;
    logic [5:0]  ctrl;
    logic [31:0] rsd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid, flush, mem_stall;
  logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
  logic [3:0]  id_alu_opcode;
  logic [5:0]  id_func, id_ctrl;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        stall_id, ex_valid;
  logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [3:0]  ex_alu_opcode;
  logic [5:0]  ex_func, ex_ctrl;
  logic [4:0]  ex_rs, ex_rt, ex_dest;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt, bubble_cnt;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];
  exp_t last_cap;

  always #5 clk = ~clk;

  id_ex_stage_reg #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_alu_opcode(id_alu_opcode), .id_func(id_func),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_ctrl(id_ctrl),
    .flush(flush), .mem_stall(mem_stall), .stall_id(stall_id),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_alu_opcode(ex_alu_opcode),
    .ex_func(ex_func), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
    .ex_ctrl(ex_ctrl)
`ifdef ID_EX_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rsd_of(input logic [31:0] pc);
    return {16'hDA7A, pc[15:0]};
  endfunction

  function automatic stim_t mk(input logic [31:0] pc, input logic [3:0] op, input logic [5:0] fn,
                               input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                               input logic [5:0] ctrl, input logic [4:0] dest);
    stim_t s;
    s.v = 1'b1; s.pc = pc; s.op = op; s.fn = fn; s.rs = rs; s.rt = rt; s.rd = rd;
    s.ctrl = ctrl; s.dest = dest; s.flush = 1'b0; s.mstall = 1'b0;
    return s;
  endfunction

  // ctrl bits: {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst}
  function automatic stim_t addu(input logic [31:0] pc, input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return mk(pc, 4'd0, 6'h21, rs, rt, rd, 6'b100001, rd);
  endfunction
  function automatic stim_t lw(input logic [31:0] pc, input logic [4:0] rt, input logic [4:0] rs);
    return mk(pc, 4'd1, 6'h00, rs, rt, 5'd0, 6'b110110, rt);
  endfunction
  function automatic stim_t ori(input logic [31:0] pc, input logic [4:0] rt, input logic [4:0] rs);
    return mk(pc, 4'd4, 6'h00, rs, rt, 5'd0, 6'b100010, rt);
  endfunction
  function automatic stim_t sw(input logic [31:0] pc, input logic [4:0] rt, input logic [4:0] rs);
    return mk(pc, 4'd1, 6'h00, rs, rt, 5'd0, 6'b001010, rt);
  endfunction

  function automatic exp_t cap(input stim_t s);
    exp_t e;
    e.v = 1'b1; e.pc = s.pc; e.op = s.op; e.fn = s.fn; e.dest = s.dest;
    e.ctrl = s.ctrl; e.rsd = rsd_of(s.pc);
    return e;
  endfunction

  function automatic exp_t bub();
    exp_t e;
    e.v = 1'b0; e.pc = '0; e.op = '0; e.fn = '0; e.dest = '0; e.ctrl = '0; e.rsd = '0;
    return e;
  endfunction

  task automatic apply(input stim_t s);
    id_valid = s.v; id_pc = s.pc; id_alu_opcode = s.op; id_func = s.fn;
    id_rs = s.rs; id_rt = s.rt; id_rd = s.rd; id_ctrl = s.ctrl;
    id_rs_data = rsd_of(s.pc); id_rt_data = ~rsd_of(s.pc); id_imm = s.pc << 2;
    flush = s.flush; mem_stall = s.mstall;
  endtask

  task automatic run(input string name, input stim_t s, input logic exp_stall, input exp_t e);
    apply(s);
    #1 chk({name, ".stall_id"}, {31'd0, stall_id}, {31'd0, exp_stall});
    @(posedge clk);
    q.push_back(e);
    if (e.v) last_cap = e;
    #1;
  endtask

  // Monitor: one expected EX state per capture edge, checked mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.v});
        chk("ex_ctrl", {26'd0, ex_ctrl}, {26'd0, e.ctrl});
        chk("ex_alu_opcode", {28'd0, ex_alu_opcode}, {28'd0, e.op});
        chk("ex_func", {26'd0, ex_func}, {26'd0, e.fn});
        chk("ex_dest", {27'd0, ex_dest}, {27'd0, e.dest});
        if (e.v) begin
          chk("ex_pc", ex_pc, e.pc);
          chk("ex_rs_data", ex_rs_data, e.rsd);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    stim_t s, a;
    exp_t  hold;
    // Reset with every input driven nonzero.
    id_valid = 1'b1; id_pc = 32'hFFFF_FFF0; id_alu_opcode = 4'hF; id_func = 6'h3F;
    id_rs_data = 32'h1234_5678; id_rt_data = 32'h9ABC_DEF0; id_imm = 32'hFFFF_0001;
    id_rs = 5'd7; id_rt = 5'd9; id_rd = 5'd11; id_ctrl = 6'h3F; flush = 1'b1; mem_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst.ex_ctrl", {26'd0, ex_ctrl}, 32'd0);
    chk("rst.ex_pc", ex_pc, 32'd0);
    chk("rst.ex_imm", ex_imm, 32'd0);
    chk("rst.ex_dest", {27'd0, ex_dest}, 32'd0);
    chk("rst.stall_id0", {31'd0, stall_id}, 32'd0);
    mem_stall = 1'b1;
    #1 chk("rst.stall_id1", {31'd0, stall_id}, 32'd1);
`ifdef ID_EX_PERF_CNT_EN
    chk("rst.stall_cnt", stall_cnt, 32'd0);
    chk("rst.bubble_cnt", bubble_cnt, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    s = addu(32'h100, 5'd3, 5'd1, 5'd2);    run("addu",      s, 1'b0, cap(s));
    s = lw(32'h104, 5'd5, 5'd1);            run("lw5",       s, 1'b0, cap(s));
    a = addu(32'h108, 5'd6, 5'd5, 5'd2);    run("lu.stall",  a, 1'b1, bub());
                                            run("lu.resume", a, 1'b0, cap(a));
    s = lw(32'h10C, 5'd0, 5'd1);            run("lw0",       s, 1'b0, cap(s));
    s = addu(32'h110, 5'd7, 5'd0, 5'd0);    run("use0",      s, 1'b0, cap(s));
    s = lw(32'h114, 5'd5, 5'd2);            run("lw5b",      s, 1'b0, cap(s));
    s = ori(32'h118, 5'd5, 5'd3);           run("ori.rt",    s, 1'b0, cap(s));
    s = lw(32'h11C, 5'd5, 5'd2);            run("lw5c",      s, 1'b0, cap(s));
    a = sw(32'h120, 5'd5, 5'd3);            run("sw.stall",  a, 1'b1, bub());
                                            run("sw.resume", a, 1'b0, cap(a));
    s = lw(32'h124, 5'd8, 5'd2);            run("lw8",       s, 1'b0, cap(s));
    s = addu(32'h128, 5'd9, 5'd8, 5'd1);    s.flush = 1'b1;
                                            run("flush.hz",  s, 1'b0, bub());
    s = addu(32'h200, 5'd10, 5'd1, 5'd2);   s.flush = 1'b1;
                                            run("flush",     s, 1'b0, bub());
    s = addu(32'h204, 5'd11, 5'd1, 5'd2);   run("redir",     s, 1'b0, cap(s));
    s = lw(32'h208, 5'd12, 5'd1);           run("lw12",      s, 1'b0, cap(s));
    hold = last_cap;
    a = addu(32'h20C, 5'd13, 5'd12, 5'd2);
    s = a; s.mstall = 1'b1;
    for (int i = 0; i < 3; i++)             run("mstall",    s, 1'b1, hold);
                                            run("ms.hz",     a, 1'b1, bub());
                                            run("ms.resume", a, 1'b0, cap(a));
    s = a; s.v = 1'b0;                      run("idle",      s, 1'b0, bub());
`ifdef ID_EX_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, 32'd3);
    chk("bubble_cnt", bubble_cnt, 32'd6);
`endif

    // Asynchronous reset in the middle of a load-use stall.
    s = lw(32'h300, 5'd14, 5'd1);           run("lw14",      s, 1'b0, cap(s));
    @(negedge clk);
    #1;
    a = addu(32'h304, 5'd15, 5'd14, 5'd2);
    apply(a);
    #1 chk("arst.pre_stall", {31'd0, stall_id}, 32'd1);
    rst = 1'b1;
    #1;
    chk("arst.ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("arst.ex_ctrl", {26'd0, ex_ctrl}, 32'd0);
    chk("arst.ex_dest", {27'd0, ex_dest}, 32'd0);
    chk("arst.ex_pc", ex_pc, 32'd0);
    chk("arst.stall_id", {31'd0, stall_id}, 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
                                            run("arst.cap",  a, 1'b0, cap(a));
`ifdef ID_EX_PERF_CNT_EN
    chk("arst.stall_cnt", stall_cnt, 32'd0);
    chk("arst.bubble_cnt", bubble_cnt, 32'd0);
`endif

    repeat (2) @(negedge clk);
    #1 chk("scoreboard.drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

ID/EX pipeline register for the five-stage MIPS pipeline: captures decoded instruction fields and control bits from the decode stage and presents them, one cycle later, to the execute stage (ALU control, ALU, operand muxes). Contains the load-use hazard detector, which stalls IF/ID and inserts a bubble. Also handles flush from jr/branch resolution and hold from downstream memory stalls.

## Interface
- `XLEN`, 32, width of PC, operand and immediate datapaths
- `clk`  in  1  pipeline clock, rising edge
- `rst`  in  1  asynchronous reset, active high
- `id_valid`  in  1  ID holds a real instruction
- `id_pc`  in  XLEN  PC of ID instruction
- `id_alu_opcode`  in  4  main-decoder ALU opcode (0 = R-type, use func)
- `id_func`  in  6  instruction func field
- `id_rs_data`, `id_rt_data`  in  XLEN  register-file read data
- `id_imm`  in  XLEN  extended immediate
- `id_rs`, `id_rt`, `id_rd`  in  5  register specifiers
- `id_ctrl`  in  6  packed control {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst}
- `flush`  in  1  kill the instruction currently in ID (jr/branch taken)
- `mem_stall`  in  1  downstream stall; hold EX contents
- `stall_id`  out  1  hold PC and IF/ID this cycle (combinational)
- `ex_valid`  out  1  EX holds a real instruction
- `ex_pc`, `ex_rs_data`, `ex_rt_data`, `ex_imm`  out  XLEN  registered copies
- `ex_alu_opcode`  out  4; `ex_func`  out  6; `ex_rs`, `ex_rt`  out  5
- `ex_dest`  out  5  destination register (reg_dst ? rd : rt), resolved at capture
- `ex_ctrl`  out  6  registered control
- `stall_cnt`, `bubble_cnt`  out  32  performance counters (only with `ID_EX_PERF_CNT_EN`)

## Operation
- Hazard: `hz = ex_valid & ex_ctrl.mem_read & ex_dest!=0 & id_valid & (ex_dest==id_rs | (ex_dest==id_rt & uses_rt))`, where `uses_rt = !id_ctrl.alu_src | id_ctrl.mem_write`.
- `stall_id = mem_stall | (hz & !flush)`.
- Per rising edge, in priority order:
  - `mem_stall`: hold all outputs unchanged (flush also ignored; the upstream redirect source repeats it).
  - `flush | hz | !id_valid`: load a bubble. `ex_valid`=0, `ex_ctrl`=0, `ex_alu_opcode`=0, `ex_func`=0, `ex_dest`=0. Data fields are don't-care; they are loaded from ID.
  - Otherwise, capture all ID fields with `ex_valid`=1.
- A bubble never writes the register file or memory; zero opcode/func leaves ALU control holding its prior value, which is harmless.
- `ex_dest` of $0 never triggers a hazard.

## Timing
- Capture latency: 1 cycle from ID to EX outputs. `stall_id` is zero-latency combinational from the current EX state and ID inputs.
- Load-use stall: exactly one cycle of stall and one bubble per dependent load; the next edge captures the held ID instruction.
- Reset: every output register is 0 (`ex_valid`=0, `ex_ctrl`=0, all data 0), and counters are 0. `stall_id` then depends only on `mem_stall`.
- Reset asserted mid-stall: state clears immediately, with no pending bubble or hold.
- Simultaneous `flush` and `hz`: a bubble is loaded and `stall_id`=0, so IF takes the redirect.

## Configuration
- `ID_EX_PERF_CNT_EN` defined: `stall_cnt` and `bubble_cnt` ports and registers exist.
  - `stall_cnt` increments on each edge where `hz & !flush & !mem_stall`.
  - `bubble_cnt` increments on each edge a bubble is loaded.
  - Both saturate at 2^32-1 and reset to 0.
- Undefined: both ports and registers are absent, and behaviour is otherwise identical.

## Structure
- Shared package `pipe_pkg` holds:
  - `ctrl_t` packed struct (field order as `id_ctrl`);
  - ALU opcode constants `ALU_OP_RTYPE`=0, `ALU_OP_ADD`=1, `ALU_OP_SUB`=2, `ALU_OP_LUI`=3, `ALU_OP_OR`=4;
  - func constants `FUNC_ADDU`=6'b100001, `FUNC_SUBU`=6'b100011, `FUNC_JR`=6'b001000.
- One sub-module: `load_use_detect`, purely combinational, producing `hz`.

## Test plan
- Reset with all inputs nonzero: every output is 0 and `stall_id`=`mem_stall`. Release reset, feed addu (opcode 0, func 0x21, rd=3): the next cycle gives `ex_valid`=1, `ex_dest`=3, and `ex_func`=0x21.
- lw $5 then addu using rs=5: `stall_id`=1 for one cycle, then a bubble (`ex_valid`=0, `ex_ctrl`=0), then addu captured. `stall_cnt`=1, `bubble_cnt`=1.
- lw $0 then consumer of $0: no stall. lw $5 then ori with rt=5 (`alu_src`=1): no stall. lw $5 then sw with rt=5: stall.
- `flush` together with a load-use hazard: `stall_id`=0 and a bubble is loaded. `flush` alone with a valid ID: a bubble is loaded.
- `mem_stall` held for 3 cycles mid-stream: outputs stay frozen, `stall_id`=1, and counters are unchanged. On release, capture resumes with no lost or duplicated instruction.
- Assert `rst` asynchronously mid-cycle during a load-use stall: outputs clear before the next edge, and no bubble follows reset release.
